// File: rtl/config_target_pkg.sv
// rtl/config_target_pkg.sv - technology target selection shared by the tech wrapper cells
package config_target_pkg;

    typedef enum logic [1:0] {
        TARGET_GENERIC = 2'd0,
        TARGET_ASIC    = 2'd1,
        TARGET_FPGA    = 2'd2
    } target_t;

    localparam target_t TARGET = TARGET_GENERIC;

endpackage

// File: rtl/ipad_debounce_pkg.sv
// rtl/ipad_debounce_pkg.sv - shared types and limits for the pad input debouncer
package ipad_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } debounce_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic bit sync_stages_ok(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/ibuf_tech.sv
// rtl/ibuf_tech.sv - technology input pad buffer wrapper
module ibuf_tech
    import config_target_pkg::*;
#(
    parameter target_t TARGET_SEL = TARGET
) (
    input  logic pad,
    output logic data
);

    // Every target maps to a plain buffer here; a real library cell can be
    // dropped into the matching branch without touching the instantiating logic.
    generate
        if (TARGET_SEL == TARGET_FPGA) begin : g_fpga
            assign data = pad;
        end else if (TARGET_SEL == TARGET_ASIC) begin : g_asic
            assign data = pad;
        end else begin : g_generic
            assign data = pad;
        end
    endgenerate

endmodule

// File: rtl/ipad_debounce.sv
// rtl/ipad_debounce.sv - pad input synchroniser and glitch filter with edge strobes
module ipad_debounce
    import ipad_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 16,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_pad,
    input  logic [CNT_WIDTH-1:0] i_hold_cycles,
    output logic                 o_level,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_busy
);

    generate
        if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
            $error("ipad_debounce: SYNC_STAGES out of range 2..4");
        end
    endgenerate

    logic                 pad_buf;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
    logic                 s;

    debounce_state_t      state;
    debounce_state_t      state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] hold_eff;
    logic                 accept;

    ibuf_tech u_ibuf (
        .pad  (i_pad),
        .data (pad_buf)
    );

    // Synchroniser chain: only sync[0] ever sees the asynchronous pad value.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_buf};
        end
    end

    assign s        = sync[SYNC_STAGES-1];
    assign hold_eff = (i_hold_cycles == '0) ? CNT_WIDTH'(1) : i_hold_cycles;
    assign cnt_inc  = cnt + CNT_WIDTH'(1);

    // Next-state decode; a ">=" threshold lets a lowered hold take effect at once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            STABLE: begin
                if (s == o_level) begin
                    cnt_nxt = '0;
                end else if (hold_eff == CNT_WIDTH'(1)) begin
                    accept = 1'b1;
                end else begin
                    cnt_nxt   = CNT_WIDTH'(1);
                    state_nxt = FILTER;
                end
            end
            FILTER: begin
                if (s == o_level) begin
                    cnt_nxt   = '0;
                    state_nxt = STABLE;
                end else if (cnt_inc >= hold_eff) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = STABLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = STABLE;
            end
        endcase
    end

    // Filter state, accepted level and single-cycle strobes that coincide with the level update.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= STABLE;
            cnt     <= '0;
            o_level <= RESET_VALUE;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            o_busy <= (state_nxt == FILTER);
            o_rise <= accept & s;
            o_fall <= accept & ~s;
            if (accept) begin
                o_level <= s;
            end
        end
    end

endmodule

// File: tb/tb_ipad_debounce.sv
// tb/tb_ipad_debounce.sv - scoreboard bench for the pad input debouncer
module tb_ipad_debounce;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pad = 1'b1;
    logic [15:0] hold = 16'd4;
    logic        level;
    logic        rise;
    logic        fall;
    logic        busy;

    typedef struct {
        bit is_rise;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ipad_debounce #(
        .SYNC_STAGES (2),
        .CNT_WIDTH   (16),
        .RESET_VALUE (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_pad         (pad),
        .i_hold_cycles (hold),
        .o_level       (level),
        .o_rise        (rise),
        .o_fall        (fall),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input bit is_rise, input int lat);
        q.push_back('{is_rise, cyc + lat});
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (rise || fall) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rise, fall}, 0);
                end else begin
                    e = q.pop_front();
                    check("pulse_rise", rise, int'(e.is_rise));
                    check("pulse_fall", fall, int'(!e.is_rise));
                    check("pulse_cycle", cyc, e.at);
                    check("level_after_pulse", level, int'(e.is_rise));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with pad high: outputs held at reset value.
        repeat (5) @(negedge clk);
        check("reset_level", level, 0);
        check("reset_busy", busy, 0);
        check("reset_rise", rise, 0);
        check("reset_fall", fall, 0);

        // Release with H=4: rise 2+4 edges after capture.
        busy_cnt = 0;
        nrst = 1'b1;
        expect_pulse(1'b1, 6);
        drain("reset_release", 20);
        check("release_level", level, 1);
        check("release_busy_cycles", busy_cnt, 3);

        // Hold 0 behaves as hold 1: fall after 3 edges, never busy.
        repeat (3) @(negedge clk);
        hold = 16'd0;
        busy_cnt = 0;
        pad = 1'b0;
        expect_pulse(1'b0, 3);
        drain("hold0", 10);
        check("hold0_busy_cycles", busy_cnt, 0);

        // Glitch of 7 cycles with hold 10 is rejected.
        repeat (3) @(negedge clk);
        hold = 16'd10;
        busy_cnt = 0;
        pad = 1'b1;
        repeat (7) @(negedge clk);
        pad = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_level", level, 0);
        check("glitch_busy_cycles", busy_cnt, 7);

        // Clean step with hold 10: rise 12 edges after capture, busy 9 cycles.
        busy_cnt = 0;
        pad = 1'b1;
        expect_pulse(1'b1, 12);
        drain("clean_step", 30);
        check("clean_busy_cycles", busy_cnt, 9);

        // Hold 1: fall after 3 edges, never busy.
        repeat (3) @(negedge clk);
        hold = 16'd1;
        busy_cnt = 0;
        pad = 1'b0;
        expect_pulse(1'b0, 3);
        drain("hold1", 10);
        check("hold1_busy_cycles", busy_cnt, 0);

        // Hold lowered 100 -> 20 at cnt=50: accepted on the next edge.
        repeat (3) @(negedge clk);
        hold = 16'd100;
        busy_cnt = 0;
        pad = 1'b1;
        expect_pulse(1'b1, 53);
        repeat (52) @(negedge clk);
        check("mid_dec_busy_before", busy, 1);
        hold = 16'd20;
        drain("mid_decrease", 20);
        check("mid_dec_busy_cycles", busy_cnt, 50);

        // Hold raised 100 -> 200 at cnt=5: accepted when cnt+1 reaches 200.
        repeat (3) @(negedge clk);
        hold = 16'd100;
        busy_cnt = 0;
        pad = 1'b0;
        expect_pulse(1'b0, 202);
        repeat (7) @(negedge clk);
        hold = 16'd200;
        drain("mid_increase", 300);
        check("mid_inc_busy_cycles", busy_cnt, 199);

        // Reset at cnt=30 with hold 50 aborts the filter; refiltered after release.
        repeat (3) @(negedge clk);
        hold = 16'd50;
        busy_cnt = 0;
        pad = 1'b1;
        repeat (32) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        nrst = 1'b0;
        #1;
        check("rst_mid_level", level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rise", rise, 0);
        @(negedge clk);
        busy_cnt = 0;
        nrst = 1'b1;
        expect_pulse(1'b1, 52);
        drain("rst_mid_release", 80);
        check("rst_mid_busy_cycles", busy_cnt, 49);
        check("final_level", level, 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
